// File: rtl/vdc_pkg.sv
// Shared definitions for the video slot arbiter: FSM states, request bit
// positions, the fetch-window margin and the refresh build switch.
// Build option: define VDC_REFRESH_EN to enable DRAM refresh slots.
package vdc_pkg;

`ifdef VDC_REFRESH_EN
    localparam bit REFRESH_EN = 1'b1;
`else
    localparam bit REFRESH_EN = 1'b0;
`endif

    localparam int RQ_CHAR = 0;
    localparam int RQ_SCRN = 1;
    localparam int RQ_ATTR = 2;
    localparam int RQ_CPU  = 3;

    localparam int FETCH_MARGIN = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SLOT = 1'b1
    } state_t;

endpackage

// File: rtl/vdc_slotwin.sv
// Column window decoder for the slot arbiter: refresh window, char window
// and screen/attribute fetch window. Purely combinational.
// The refresh window is forced inactive unless VDC_REFRESH_EN is defined.
module vdc_slotwin
    import vdc_pkg::*;
(
    input  logic [7:0] i_col,
    input  logic [7:0] i_hd,
    input  logic [7:0] i_ht,
    input  logic [3:0] i_drr,
    output logic       o_rfshWin,
    output logic       o_charWin,
    output logic       o_fetchWin
);

    logic        [8:0] w_col9;
    logic        [8:0] w_rfshStart;
    logic        [8:0] w_rfshEnd;
    logic signed [9:0] w_colS;
    logic signed [9:0] w_htS;
    logic signed [9:0] w_margin;

    // Refresh window is evaluated in 9 bits so hd+drr past 255 does not wrap
    assign w_col9      = {1'b0, i_col};
    assign w_rfshStart = {1'b0, i_hd};
    assign w_rfshEnd   = {1'b0, i_hd} + {5'b0_0000, i_drr};
    assign o_rfshWin   = REFRESH_EN && (w_col9 >= w_rfshStart) && (w_col9 < w_rfshEnd);

    // Character fetches only happen in the displayed part of the line
    assign o_charWin = (i_col < i_hd);

    // Signed arithmetic keeps tiny totals (ht<4) from wrapping into a huge window
    assign w_colS     = signed'({2'b00, i_col});
    assign w_htS      = signed'({2'b00, i_ht});
    assign w_margin   = 10'(FETCH_MARGIN);
    assign o_fetchWin = (w_colS >= w_margin) && (w_colS < (w_htS - w_margin));

endmodule

// File: rtl/vdc_slotarb.sv
// Per-column memory slot arbiter for the video controller. Each column one
// owner is chosen (refresh, char, screen, attribute or CPU), held for the
// column and completed with a one-cycle done pulse. The CPU is protected
// from starvation by a saturating lost-slot counter.
// Build option: define VDC_REFRESH_EN to enable refresh slots and rfsh_addr.
module vdc_slotarb
    import vdc_pkg::*;
#(
    parameter int unsigned CPU_STARVE_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       newCol,
    input  logic       endCol,
    input  logic [7:0] col,
    input  logic [7:0] reg_hd,
    input  logic [7:0] reg_ht,
    input  logic [3:0] reg_drr,
    input  logic       visible0,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [3:0] done,
    output logic       rfsh,
    output logic [7:0] rfsh_addr,
    output logic       starve
);

    localparam logic [7:0] STARVE_MAX = 8'(CPU_STARVE_MAX);

    state_t     r_state;
    logic [3:0] r_grant;
    logic [3:0] r_done;
    logic       r_rfsh;
    logic [7:0] r_rfshAddr;
    logic [7:0] r_starveCnt;

    logic       w_rfshWin;
    logic       w_charWin;
    logic       w_fetchWin;
    logic       w_starveNow;
    logic [3:0] w_grantNext;
    logic       w_rfshNext;
    logic [7:0] w_cntNext;
    logic       w_decide;
    logic       w_complete;

    vdc_slotwin u_win (
        .i_col      (col),
        .i_hd       (reg_hd),
        .i_ht       (reg_ht),
        .i_drr      (reg_drr),
        .o_rfshWin  (w_rfshWin),
        .o_charWin  (w_charWin),
        .o_fetchWin (w_fetchWin)
    );

    assign w_starveNow = (r_starveCnt >= STARVE_MAX);
    assign w_decide    = enable && newCol;
    assign w_complete  = !enable && endCol && (r_state == S_SLOT);

    // Fixed-priority owner selection and next starvation count for this column
    always_comb begin
        w_grantNext = 4'b0000;
        w_rfshNext  = 1'b0;
        w_cntNext   = r_starveCnt;
        if (w_rfshWin) begin
            w_rfshNext = 1'b1;
        end else if (req[RQ_CHAR] && visible0 && w_charWin) begin
            w_grantNext[RQ_CHAR] = 1'b1;
        end else if (req[RQ_CPU] && w_starveNow) begin
            w_grantNext[RQ_CPU] = 1'b1;
        end else if (req[RQ_SCRN] && w_fetchWin) begin
            w_grantNext[RQ_SCRN] = 1'b1;
        end else if (req[RQ_ATTR] && w_fetchWin) begin
            w_grantNext[RQ_ATTR] = 1'b1;
        end else if (req[RQ_CPU]) begin
            w_grantNext[RQ_CPU] = 1'b1;
        end

        if (w_grantNext[RQ_CPU] || !req[RQ_CPU]) begin
            w_cntNext = 8'd0;
        end else if (!w_rfshWin && (r_starveCnt < STARVE_MAX)) begin
            w_cntNext = r_starveCnt + 8'd1;
        end
    end

    // Slot FSM: decide on column start, complete on column end; a decision in
    // S_SLOT silently retires the previous slot (its refresh still counts)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant     <= 4'b0000;
            r_done      <= 4'b0000;
            r_rfsh      <= 1'b0;
            r_rfshAddr  <= 8'd0;
            r_starveCnt <= 8'd0;
        end else begin
            r_done <= 4'b0000;
            if (w_decide) begin
                if (r_rfsh) begin
                    r_rfshAddr <= r_rfshAddr + 8'd1;
                end
                r_grant     <= w_grantNext;
                r_rfsh      <= w_rfshNext;
                r_starveCnt <= w_cntNext;
                r_state     <= S_SLOT;
            end else if (w_complete) begin
                if (r_rfsh) begin
                    r_rfshAddr <= r_rfshAddr + 8'd1;
                end
                r_done  <= r_grant;
                r_grant <= 4'b0000;
                r_rfsh  <= 1'b0;
                r_state <= S_IDLE;
            end
        end
    end

    assign grant     = r_grant;
    assign done      = r_done;
    assign rfsh      = r_rfsh;
    assign rfsh_addr = r_rfshAddr;
    assign starve    = w_starveNow;

endmodule

// File: tb/tb_vdc_slotarb.sv
// Scoreboard bench for vdc_slotarb. Stimulus tasks queue the expected
// response for every decision, completion and reset; monitors pop and
// compare whenever the DUT reaches one of those points.
module tb_vdc_slotarb;

`ifdef VDC_REFRESH_EN
    localparam bit RF = 1'b1;
`else
    localparam bit RF = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [3:0] grant;
        logic       rfsh;
        logic [7:0] addr;
        logic       starve;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable, newCol, endCol, visible0;
    logic [7:0] col, reg_hd, reg_ht;
    logic [3:0] reg_drr, req;
    logic [3:0] grant, done;
    logic       rfsh, starve;
    logic [7:0] rfsh_addr;

    int   total = 0;
    int   bad   = 0;
    bit   checking = 1'b0;
    bit   wasDecide = 1'b0;
    bit   wasComplete = 1'b0;
    exp_t decQ[$];
    exp_t cmpQ[$];
    exp_t rstQ[$];
    exp_t eMon;
    exp_t eRst;

    vdc_slotarb #(.CPU_STARVE_MAX(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .newCol    (newCol),
        .endCol    (endCol),
        .col       (col),
        .reg_hd    (reg_hd),
        .reg_ht    (reg_ht),
        .reg_drr   (reg_drr),
        .visible0  (visible0),
        .req       (req),
        .grant     (grant),
        .done      (done),
        .rfsh      (rfsh),
        .rfsh_addr (rfsh_addr),
        .starve    (starve)
    );

    always #5 clk = ~clk;

    // One comparison: counts it and reports a failure with both values
    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Note which kind of edge the DUT just saw
    always @(posedge clk) begin
        wasDecide   = !reset && enable && newCol;
        wasComplete = !reset && !enable && endCol;
    end

    // Monitor: after each edge compare against the queued expectation
    always @(negedge clk) begin
        if (checking) begin
            if (wasDecide) begin
                if (decQ.size() == 0) begin
                    checkOutput("decision queue empty", 8'd1, 8'd0);
                end else begin
                    eMon = decQ.pop_front();
                    checkOutput({eMon.name, " grant"}, {4'b0, grant}, {4'b0, eMon.grant});
                    checkOutput({eMon.name, " rfsh"}, {7'b0, rfsh}, {7'b0, eMon.rfsh});
                    checkOutput({eMon.name, " rfsh_addr"}, rfsh_addr, eMon.addr);
                    checkOutput({eMon.name, " starve"}, {7'b0, starve}, {7'b0, eMon.starve});
                    checkOutput({eMon.name, " no done"}, {4'b0, done}, 8'd0);
                end
            end else if (wasComplete) begin
                if (cmpQ.size() == 0) begin
                    checkOutput("completion queue empty", 8'd1, 8'd0);
                end else begin
                    eMon = cmpQ.pop_front();
                    checkOutput({eMon.name, " done"}, {4'b0, done}, {4'b0, eMon.grant});
                    checkOutput({eMon.name, " grant cleared"}, {4'b0, grant}, 8'd0);
                    checkOutput({eMon.name, " rfsh cleared"}, {7'b0, rfsh}, 8'd0);
                    checkOutput({eMon.name, " rfsh_addr after"}, rfsh_addr, eMon.addr);
                    checkOutput({eMon.name, " starve after"}, {7'b0, starve}, {7'b0, eMon.starve});
                end
            end else begin
                checkOutput("idle done", {4'b0, done}, 8'd0);
            end
        end
    end

    // Reset monitor: outputs must clear right after reset rises, without a clock
    always @(posedge reset) begin
        #1;
        if (rstQ.size() == 0) begin
            checkOutput("reset queue empty", 8'd1, 8'd0);
        end else begin
            eRst = rstQ.pop_front();
            checkOutput({eRst.name, " grant"}, {4'b0, grant}, 8'd0);
            checkOutput({eRst.name, " done"}, {4'b0, done}, 8'd0);
            checkOutput({eRst.name, " rfsh"}, {7'b0, rfsh}, 8'd0);
            checkOutput({eRst.name, " rfsh_addr"}, rfsh_addr, 8'd0);
            checkOutput({eRst.name, " starve"}, {7'b0, starve}, 8'd0);
        end
    end

    task automatic pushExp(inout exp_t q[$], input string n, input logic [3:0] g,
                           input logic r, input logic [7:0] a, input logic s);
        exp_t e;
        e.name = n; e.grant = g; e.rfsh = r; e.addr = a; e.starve = s;
        q.push_back(e);
    endtask

    task automatic decideOnly(input string n, input logic [7:0] c, input logic [3:0] r,
                              input logic v, input logic [3:0] eg, input logic er,
                              input logic [7:0] ea, input logic es);
        @(negedge clk);
        #2;
        col = c; req = r; visible0 = v;
        enable = 1'b1; newCol = 1'b1; endCol = 1'b0;
        pushExp(decQ, n, eg, er, ea, es);
    endtask

    task automatic completeOnly(input string n, input logic [3:0] ed,
                                input logic [7:0] ea, input logic es);
        @(negedge clk);
        #2;
        enable = 1'b0; newCol = 1'b0; endCol = 1'b1;
        pushExp(cmpQ, n, ed, 1'b0, ea, es);
    endtask

    task automatic applyStimulus(input string n, input logic [7:0] c, input logic [3:0] r,
                                 input logic v, input logic [3:0] eg, input logic er,
                                 input logic [7:0] ea, input logic es);
        decideOnly(n, c, r, v, eg, er, ea, es);
        completeOnly(n, eg, ea + {7'b0, er}, es);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #2;
            enable = 1'b0; newCol = 1'b0; endCol = 1'b0;
        end
    endtask

    task automatic applyReset(input string n);
        @(negedge clk);
        #2;
        enable = 1'b0; newCol = 1'b0; endCol = 1'b0;
        pushExp(rstQ, n, 4'b0, 1'b0, 8'd0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Hard stop in case something hangs
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios
    initial begin
        logic [7:0] a;
        logic       inWin;
        logic [3:0] eg;
        logic [3:0] stGrant [9];
        logic       stFlag  [9];

        reset = 1'b0; enable = 1'b0; newCol = 1'b0; endCol = 1'b0;
        col = 8'd0; reg_hd = 8'd80; reg_ht = 8'd100; reg_drr = 4'd5;
        visible0 = 1'b0; req = 4'b0000;

        applyReset("init reset");
        checking = 1'b1;

        // Refresh window 80..84 with a CPU-only request
        a = 8'd0;
        for (int c = 78; c <= 86; c++) begin
            inWin = RF && (c >= 80) && (c <= 84);
            eg    = inWin ? 4'b0000 : 4'b1000;
            applyStimulus($sformatf("refresh col%0d", c), 8'(c), 4'b1000, 1'b0, eg, inWin, a, 1'b0);
            a = a + {7'b0, inWin};
        end
        // Window 250..259 must not wrap to 250..3
        reg_hd = 8'd250; reg_drr = 4'd10;
        applyStimulus("rfsh 9-bit col252", 8'd252, 4'b1000, 1'b0,
                      RF ? 4'b0000 : 4'b1000, RF, a, 1'b0);
        applyStimulus("rfsh 9-bit col3", 8'd3, 4'b1000, 1'b0, 4'b1000, 1'b0,
                      a + {7'b0, RF}, 1'b0);
        // Empty refresh window when drr=0
        reg_hd = 8'd80; reg_drr = 4'd0;
        applyStimulus("drr0 col80 cpu", 8'd80, 4'b1000, 1'b0, 4'b1000, 1'b0,
                      a + {7'b0, RF}, 1'b0);

        // Char window versus screen fetch
        applyReset("char reset");
        reg_hd = 8'd80; reg_drr = 4'd5; reg_ht = 8'd100;
        applyStimulus("char vis col10", 8'd10, 4'b0011, 1'b1, 4'b0001, 1'b0, 8'd0, 1'b0);
        applyStimulus("char novis col10", 8'd10, 4'b0011, 1'b0, 4'b0010, 1'b0, 8'd0, 1'b0);
        applyStimulus("char edge col79", 8'd79, 4'b0001, 1'b1, 4'b0001, 1'b0, 8'd0, 1'b0);
        reg_drr = 4'd0;
        applyStimulus("char edge col80", 8'd80, 4'b0001, 1'b1, 4'b0000, 1'b0, 8'd0, 1'b0);
        applyStimulus("attr col20", 8'd20, 4'b0100, 1'b1, 4'b0100, 1'b0, 8'd0, 1'b0);

        // Starvation with max 3: three screen slots, then the CPU
        applyReset("starve reset");
        reg_hd = 8'd80; reg_drr = 4'd5; reg_ht = 8'd127;
        stGrant = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010,
                    4'b0010, 4'b0010, 4'b1000, 4'b0010};
        stFlag  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            applyStimulus($sformatf("starve col%0d", i + 2), 8'(i + 2), 4'b1110, 1'b0,
                          stGrant[i], 1'b0, 8'd0, stFlag[i]);
        end

        // Tiny horizontal total: no fetch window at all
        applyReset("smallht reset");
        reg_ht = 8'd3;
        for (int c = 0; c < 4; c++) begin
            applyStimulus($sformatf("ht3 col%0d", c), 8'(c), 4'b0110, 1'b0,
                          4'b0000, 1'b0, 8'd0, 1'b0);
        end

        // 256 refresh slots wrap the row counter back to zero
        applyReset("wrap reset");
        reg_hd = 8'd0; reg_drr = 4'd15; reg_ht = 8'd100;
        a = 8'd0;
        for (int i = 0; i < 257; i++) begin
            applyStimulus($sformatf("wrap slot%0d", i), 8'd0, 4'b0000, 1'b0,
                          4'b0000, RF, a, 1'b0);
            a = a + {7'b0, RF};
        end

        // Reset in the middle of a CPU slot
        applyReset("midslot pre reset");
        reg_hd = 8'd80; reg_drr = 4'd5; reg_ht = 8'd100;
        decideOnly("midslot grant", 8'd10, 4'b1000, 1'b0, 4'b1000, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        #2;
        enable = 1'b0; newCol = 1'b0; endCol = 1'b1;
        pushExp(rstQ, "midslot reset", 4'b0, 1'b0, 8'd0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        #2;
        reset = 1'b0;
        pushExp(cmpQ, "midslot late endCol", 4'b0000, 1'b0, 8'd0, 1'b0);
        applyStimulus("midslot next", 8'd11, 4'b1000, 1'b0, 4'b1000, 1'b0, 8'd0, 1'b0);

        // Missed endCol: second decision retires the first silently
        decideOnly("missed first", 8'd10, 4'b1000, 1'b0, 4'b1000, 1'b0, 8'd0, 1'b0);
        decideOnly("missed second", 8'd11, 4'b0011, 1'b1, 4'b0001, 1'b0, 8'd0, 1'b0);
        completeOnly("missed second", 4'b0001, 8'd0, 1'b0);

        idle(3);
        checkOutput("decision queue drained", 8'(decQ.size()), 8'd0);
        checkOutput("completion queue drained", 8'(cmpQ.size()), 8'd0);
        checkOutput("reset queue drained", 8'(rstQ.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vdc_slotarb.md
VDC_SLOTARB -- requirements
Module: vdc_slotarb

Interface
REQ-001 SHALL have parameter CPU_STARVE_MAX, default 8, meaning the number of lost CPU slots (1..255) after which the CPU outranks screen and attribute fetches.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on posedge clk.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port enable, input, 1, column phase strobe; slot decisions use enable&&newCol, completions use ~enable&&endCol.
REQ-005 SHALL have ports newCol and endCol, input, 1 each, column start and column end strobes.
REQ-006 SHALL have port col, input, 8, the current column.
REQ-007 SHALL have ports reg_hd and reg_ht, input, 8 each, horizontal displayed and horizontal total.
REQ-008 SHALL have port reg_drr, input, 4, refresh slots per line.
REQ-009 SHALL have port visible0, input, 1, current row visible.
REQ-010 SHALL have port req, input, 4, level requests: bit0 char, bit1 scrn, bit2 attr, bit3 cpu.
REQ-011 SHALL have port grant, output, 4, one-hot or zero, same bit order as req.
REQ-012 SHALL have port done, output, 4, one-cycle pulse marking completion of the granted slot.
REQ-013 SHALL have port rfsh, output, 1, high while a refresh slot is owned.
REQ-014 SHALL have port rfsh_addr, output, 8, refresh row counter.
REQ-015 SHALL have port starve, output, 1, high while the starvation count is at or above CPU_STARVE_MAX.

Function
REQ-016 SHALL implement a FSM with states S_IDLE and S_SLOT.
- In S_IDLE on enable&&newCol: decide the slot owner, drive grant or rfsh, and go to S_SLOT.
- The decision SHALL be made even when no requester wins: grant=0, and S_SLOT is still entered.
REQ-017 SHALL compute the refresh window as 9-bit col>=reg_hd && col<reg_hd+reg_drr, with no 8-bit wrap; reg_drr=0 gives an empty window.
REQ-018 SHALL compute the fetch window (scrn/attr) as col>=2 && col<reg_ht-2, using signed 10-bit arithmetic; reg_ht<4 gives an empty window.
REQ-019 SHALL apply this fixed priority per slot:
1. refresh (window active);
2. char (req[0] && visible0 && col<reg_hd);
3. cpu, if starve is high;
4. scrn (req[1] && fetch window);
5. attr (req[2] && fetch window);
6. cpu (req[3]).
- The CPU SHALL never be granted inside the refresh window.
REQ-020 SHALL hold grant and rfsh stable throughout S_SLOT.
REQ-021 In S_SLOT on ~enable&&endCol SHALL:
- pulse done for exactly one cycle on the granted bit (no pulse if grant=0);
- clear grant and rfsh;
- return to S_IDLE.
REQ-022 SHALL, when enable&&newCol arrives while still in S_SLOT (missed endCol), force-complete the old slot without a done pulse and make the new decision in the same cycle.
REQ-023 SHALL increment rfsh_addr by 1 at the completion of each refresh slot, wrapping 255->0.
REQ-024 SHALL update the 8-bit starvation count at each decision:
- clear on a CPU grant or when req[3]=0;
- increment when req[3]=1, the CPU is not granted, and the refresh window is inactive;
- hold during refresh slots;
- saturate at CPU_STARVE_MAX.
REQ-025 SHALL treat requests as sampled only at the decision edge; a req change mid-slot does not affect grant.

Reset
REQ-026 SHALL drive, while reset is high: state=S_IDLE, grant=0, done=0, rfsh=0, rfsh_addr=0, starvation count=0, starve=0.
REQ-027 SHALL abort any in-flight slot on reset mid-slot with no done pulse.

Configuration
REQ-028 SHALL use macro VDC_REFRESH_EN.
- Defined: refresh window, rfsh and rfsh_addr behave as in REQ-017/019/023.
- Undefined: the refresh window is never active, rfsh=0 and rfsh_addr=0 permanently, and the CPU may win in any column.

Structure
REQ-029 SHALL take the state enum, the request bit indices (RQ_CHAR=0, RQ_SCRN=1, RQ_ATTR=2, RQ_CPU=3) and the fetch-window margin constant (2) from shared package vdc_pkg.
REQ-030 SHALL place the window comparisons (REQ-017/018) in one combinational sub-module, vdc_slotwin; all sequential logic stays in vdc_slotarb.

Verification
REQ-031 Bench SHALL cover refresh: reg_hd=80, reg_drr=5, req=4'b1000, cols 78..86 -> rfsh high at cols 80..84 only; rfsh_addr advances 0->5; CPU granted at 78, 79, 85, 86.
REQ-032 Bench SHALL cover the char window: visible0=1, reg_hd=80, req=4'b0011, col=10 -> grant=0001; with visible0=0 -> grant=0010.
REQ-033 Bench SHALL cover starvation: CPU_STARVE_MAX=3, req=4'b1110 held, reg_ht=127, cols 2..10 -> scrn granted for 3 slots, starve rises, cpu granted at the 4th slot, count clears, pattern repeats.
REQ-034 Bench SHALL cover wrap and small totals: rfsh_addr preset path of 256 refresh slots -> wraps to 0; reg_ht=3 -> scrn/attr never granted.
REQ-035 Bench SHALL cover reset mid-slot: grant=1000 held, reset asserted before endCol -> grant=0 immediately (asynchronous), no done pulse, and the next newCol decides normally.
REQ-036 Bench SHALL cover a missed endCol: two consecutive enable&&newCol decisions -> no done pulse for the first slot; the second grant is valid.
